// File: rtl/sync_fifo_gen.sv
// Parameterised single-clock FIFO: registered read data, one-cycle handshake pulses,
// occupancy count with threshold flags, and a synchronous flush that keeps data_out.
module sync_fifo_gen #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     wr_ack,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     full,
  output logic                     empty,
  output logic                     almostfull,
  output logic                     almostempty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Flags decode only from the count register, so no request input reaches an output.
  always_comb begin
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    almostfull  = (count >= AF_C) && !full;
    almostempty = (count <= AE_C) && !empty;
    wr_acc      = wr_en && !full;
    rd_acc      = rd_en && !empty;
  end

  // Storage is deliberately left out of reset; stale words are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Scoreboard bench for sync_fifo_gen: one instance at default parameters (A) and one
// at DATA_W=32, DEPTH=16, AF_LEVEL=12, AE_LEVEL=3 (B), each tracked by its own model.
module tb_sync_fifo_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, fl_a, wr_a, rd_a;
  logic [15:0] din_a, dout_a;
  logic        ack_a, ovf_a, unf_a, full_a, empty_a, af_a, ae_a;
  logic [3:0]  cnt_a;

  logic        rst_b_n, fl_b, wr_b, rd_b;
  logic [31:0] din_b, dout_b;
  logic        ack_b, ovf_b, unf_b, full_b, empty_b, af_b, ae_b;
  logic [4:0]  cnt_b;

  sync_fifo_gen dut_a (
    .clk(clk), .rst_n(rst_a_n), .flush(fl_a), .wr_en(wr_a), .data_in(din_a),
    .rd_en(rd_a), .data_out(dout_a), .wr_ack(ack_a), .overflow(ovf_a),
    .underflow(unf_a), .full(full_a), .empty(empty_a), .almostfull(af_a),
    .almostempty(ae_a), .count(cnt_a)
  );

  sync_fifo_gen #(.DATA_W(32), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .flush(fl_b), .wr_en(wr_b), .data_in(din_b),
    .rd_en(rd_b), .data_out(dout_b), .wr_ack(ack_b), .overflow(ovf_b),
    .underflow(unf_b), .full(full_b), .empty(empty_b), .almostfull(af_b),
    .almostempty(ae_b), .count(cnt_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int          dep  [2] = '{8, 16};
  int          afl  [2] = '{7, 12};
  int          ael  [2] = '{1, 3};
  int          m_cnt[2];
  logic [31:0] m_dout[2];
  bit          m_ack[2], m_ovf[2], m_unf[2];
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic compare(input int d);
    string       p;
    logic [31:0] g_cnt, g_dout;
    logic [3:0]  g_flg, e_flg;
    logic [2:0]  g_pls, e_pls;
    bit          e_full, e_empty;
    p = (d == 0) ? "A." : "B.";
    if (d == 0) begin
      g_cnt = 32'(cnt_a); g_dout = 32'(dout_a);
      g_flg = {full_a, empty_a, af_a, ae_a}; g_pls = {ack_a, ovf_a, unf_a};
    end else begin
      g_cnt = 32'(cnt_b); g_dout = dout_b;
      g_flg = {full_b, empty_b, af_b, ae_b}; g_pls = {ack_b, ovf_b, unf_b};
    end
    e_full  = (m_cnt[d] == dep[d]);
    e_empty = (m_cnt[d] == 0);
    e_flg = {e_full, e_empty, (m_cnt[d] >= afl[d]) && !e_full, (m_cnt[d] <= ael[d]) && !e_empty};
    e_pls = {m_ack[d], m_ovf[d], m_unf[d]};
    chk_eq({p, "count"}, g_cnt, 32'(m_cnt[d]));
    chk_eq({p, "flags(full,empty,af,ae)"}, 32'(g_flg), 32'(e_flg));
    chk_eq({p, "pulses(ack,ovf,unf)"}, 32'(g_pls), 32'(e_pls));
    chk_eq({p, "data_out"}, g_dout, m_dout[d]);
  endtask

  task automatic model_reset(input int d);
    m_cnt[d] = 0; m_dout[d] = '0;
    m_ack[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
    if (d == 0) qa.delete(); else qb.delete();
  endtask

  task automatic idle_inputs();
    fl_a = 0; wr_a = 0; rd_a = 0; din_a = '0;
    fl_b = 0; wr_b = 0; rd_b = 0; din_b = '0;
  endtask

  // Reset with wr_en high on the selected instance: reset must win over the request.
  task automatic do_reset(input int d);
    @(negedge clk);
    idle_inputs();
    if (d == 0) begin rst_a_n = 0; wr_a = 1; din_a = 16'hDEAD; end
    else        begin rst_b_n = 0; wr_b = 1; din_b = 32'hDEADBEEF; end
    @(posedge clk); #1;
    model_reset(d);
    compare(d);
  endtask

  task automatic cyc(input int d, input bit wr, input logic [31:0] din, input bit rd, input bit fl);
    bit wa, ra;
    logic [31:0] dv;
    @(negedge clk);
    rst_a_n = 1; rst_b_n = 1;
    idle_inputs();
    dv = (d == 0) ? {16'h0, din[15:0]} : din;
    if (d == 0) begin wr_a = wr; din_a = din[15:0]; rd_a = rd; fl_a = fl; end
    else        begin wr_b = wr; din_b = din;       rd_b = rd; fl_b = fl; end
    if (fl) begin
      if (d == 0) qa.delete(); else qb.delete();
      m_cnt[d] = 0; m_ack[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
    end else begin
      wa = wr && (m_cnt[d] < dep[d]);
      ra = rd && (m_cnt[d] > 0);
      if (ra) begin
        if (d == 0) m_dout[d] = qa.pop_front();
        else        m_dout[d] = qb.pop_front();
      end
      if (wa) begin
        if (d == 0) qa.push_back(dv); else qb.push_back(dv);
      end
      m_cnt[d] = m_cnt[d] + int'(wa) - int'(ra);
      m_ack[d] = wa; m_ovf[d] = wr && !wa; m_unf[d] = rd && !ra;
    end
    @(posedge clk); #1;
    compare(d);
  endtask

  initial begin
    rst_a_n = 0; rst_b_n = 0;
    idle_inputs();
    do_reset(0);
    do_reset(1);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Fill past full, then drain past empty.
    for (int i = 1; i <= 9; i++) cyc(0, 1, 32'(i), 0, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 1, 0);

    // Move pointers off zero, then run concurrent traffic across the wrap.
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'(16'h0050 + i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'(16'h0060 + i), 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 32'(16'h0100 + i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

    // Simultaneous access at the empty and full boundaries.
    cyc(0, 1, 32'h0000_0A11, 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 32'(16'h0200 + i), 0, 0);
    cyc(0, 1, 32'h0000_0BAD, 1, 0);

    // Flush at count 5 with a write pending, then prove the FIFO still works.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 32'h0000_F00D, 0, 1);
    cyc(0, 1, 32'h0000_BEEF, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Randomised mixed traffic with occasional flush.
    for (int i = 0; i < 60; i++)
      cyc(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0);

    // Wide/deep instance: thresholds, full, overflow.
    for (int i = 1; i <= 17; i++) cyc(1, 1, 32'hA500_0000 | 32'(i), 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'hC300_0000 | 32'(i), 0, 0);
    do_reset(1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h1234_5678, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
